// File: rtl/misc_pkg.sv
// Shared types and constants for the Misc-unit job sequencer.
package misc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FEED,
      SETTLE,
      EMIT,
      NL
   } state_t;

   localparam logic MODE_NL    = 1'b0;
   localparam logic MODE_KSORT = 1'b1;

   // Nonlinear function ids understood by the Misc nonlinear path.
   localparam logic [2:0] FUN_SIGMOID = 3'd0;
   localparam logic [2:0] FUN_TANH    = 3'd1;
   localparam logic [2:0] FUN_EXP     = 3'd2;
   localparam logic [2:0] FUN_LOG     = 3'd3;
   localparam logic [2:0] FUN_RELU    = 3'd4;

endpackage

// File: rtl/misc_ctrl_if.sv
// Operand and result valid/ready streams of the Misc job sequencer.
interface misc_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [WIDTH-1:0] out_index;
   logic             out_last;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_index, out_last
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_index, out_last
   );
endinterface

// File: rtl/misc_out_reg.sv
// One-deep registered valid/ready result stage shared by sort drain and nonlinear mode.
module misc_out_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_data,
   input  logic [WIDTH-1:0] i_index,
   input  logic             i_last,
   input  logic             i_ready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   output logic [WIDTH-1:0] o_index,
   output logic             o_last,
   output logic             o_free
);
   logic             r_valid;
   logic             r_last;
   logic [WIDTH-1:0] r_data;
   logic [WIDTH-1:0] r_index;

   // Hold a beat until taken; a new beat may replace one accepted in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_data  <= '0;
         r_index <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_last  <= i_last;
         r_data  <= i_data;
         r_index <= i_index;
      end else if (i_ready) begin
         r_valid <= 1'b0;
         r_last  <= 1'b0;
      end
   end

   assign o_free  = !r_valid || i_ready;
   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_index = r_index;
   assign o_last  = r_last;
endmodule

// File: rtl/misc_ctrl.sv
// Job sequencer for the Misc unit: k-sort feed/drain and registered nonlinear streaming.
module misc_ctrl
   import misc_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int K     = 20,
   parameter int NW    = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      cfg_mode,
   input  logic [2:0]                cfg_fun_id,
   input  logic                      cfg_asce,
   input  logic [NW-1:0]             cfg_len,
   output logic                      busy,
   output logic                      done,
   misc_ctrl_if.slave                io,
   output logic [WIDTH-1:0]          m_in,
   output logic [WIDTH-1:0]          m_index,
   output logic [2:0]                m_fun_id,
   output logic                      m_asce,
   output logic                      m_clear_reg,
   output logic                      m_load,
   input  logic [WIDTH-1:0]          m_out_nonli,
   input  logic [K-1:0][WIDTH-1:0]   m_out_ksort,
   input  logic [K-1:0][WIDTH-1:0]   m_out_ksort_index
);
   localparam int SW = (K > 1) ? $clog2(K) : 1;

   state_t           r_state, w_next;
   logic [2:0]       r_fun_id;
   logic             r_asce;
   logic [NW-1:0]    r_len, r_nout, r_cnt;
   logic [WIDTH-1:0] r_m_in, r_m_index;
   logic             r_m_load, r_done;

   logic             w_in_ready, w_in_hs, w_accept, w_done_set, w_free;
   logic             w_ld, w_ld_last;
   logic [WIDTH-1:0] w_ld_data, w_ld_index;
   logic [SW-1:0]    w_slot;

   // Number of sorted slots worth draining: never more than the sorter holds.
   function automatic logic [NW-1:0] f_nout(input logic [NW-1:0] len);
      f_nout = (len > NW'(K)) ? NW'(K) : len;
   endfunction

   assign w_slot  = r_cnt[SW-1:0];
   assign w_in_hs = w_in_ready && io.in_valid;

   // State register; reset abandons any job without a done pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Next state, stream handshakes and result-register load requests.
   always_comb begin
      w_next     = r_state;
      w_in_ready = 1'b0;
      w_accept   = 1'b0;
      w_done_set = 1'b0;
      w_ld       = 1'b0;
      w_ld_data  = '0;
      w_ld_index = '0;
      w_ld_last  = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_accept = 1'b1;
               w_next   = (cfg_mode == MODE_KSORT) ? CLEAR : NL;
            end
         end
         CLEAR: w_next = (r_len == '0) ? SETTLE : FEED;
         FEED: begin
            w_in_ready = (r_cnt != r_len);
            if (w_in_hs && (r_cnt == r_len - 1'b1)) w_next = SETTLE;
         end
         SETTLE: begin
            if (r_len == '0) begin
               w_next     = IDLE;
               w_done_set = 1'b1;
            end else begin
               w_next = EMIT;
            end
         end
         EMIT: begin
            if (w_free && (r_cnt != r_nout)) begin
               w_ld       = 1'b1;
               w_ld_data  = m_out_ksort[w_slot];
               w_ld_index = m_out_ksort_index[w_slot];
               w_ld_last  = (r_cnt == r_nout - 1'b1);
            end
            if (io.out_valid && io.out_ready && io.out_last) begin
               w_next     = IDLE;
               w_done_set = 1'b1;
            end
         end
         NL: begin
            w_in_ready = (r_cnt != r_len) && w_free;
            if (w_in_hs) begin
               w_ld      = 1'b1;
               w_ld_data = m_out_nonli;
               w_ld_last = (r_cnt == r_len - 1'b1);
            end
            if ((r_len == '0) || (io.out_valid && io.out_ready && io.out_last)) begin
               w_next     = IDLE;
               w_done_set = 1'b1;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // Job config latch, element/slot counter and the registered Misc operand port.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_fun_id  <= '0;
         r_asce    <= 1'b0;
         r_len     <= '0;
         r_nout    <= '0;
         r_cnt     <= '0;
         r_m_in    <= '0;
         r_m_index <= '0;
         r_m_load  <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_m_load <= 1'b0;
         r_done   <= w_done_set;
         if (w_accept) begin
            r_fun_id <= cfg_fun_id;
            r_asce   <= cfg_asce;
            r_len    <= cfg_len;
         end
         if (w_accept || r_state == CLEAR) begin
            r_cnt <= '0;
         end else if (r_state == SETTLE) begin
            r_cnt  <= '0;
            r_nout <= f_nout(r_len);
         end else if (w_in_hs || w_ld) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (r_state == FEED && w_in_hs) begin
            r_m_in    <= io.in_data;
            r_m_index <= WIDTH'(r_cnt);
            r_m_load  <= 1'b1;
         end
      end
   end

   misc_out_reg #(.WIDTH(WIDTH)) u_out_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_ld),
      .i_data  (w_ld_data),
      .i_index (w_ld_index),
      .i_last  (w_ld_last),
      .i_ready (io.out_ready),
      .o_valid (io.out_valid),
      .o_data  (io.out_data),
      .o_index (io.out_index),
      .o_last  (io.out_last),
      .o_free  (w_free)
   );

   assign busy        = (r_state != IDLE);
   assign done        = r_done;
   assign io.in_ready = w_in_ready;
   assign m_in        = (r_state == NL) ? io.in_data : r_m_in;
   assign m_index     = r_m_index;
   assign m_fun_id    = r_fun_id;
   assign m_asce      = r_asce;
   assign m_clear_reg = (r_state == CLEAR);
   assign m_load      = r_m_load;
endmodule

// File: tb/tb_misc_ctrl.sv
// Directed bench for misc_ctrl with a behavioural Misc unit and a result scoreboard.
module tb_misc_ctrl;
   import misc_pkg::*;

   localparam int W   = 32;
   localparam int KK  = 20;
   localparam int NWB = 16;

   typedef logic [KK-1:0][W-1:0] slots_t;
   typedef struct {
      logic [W-1:0] d;
      logic [W-1:0] i;
      logic         l;
   } beat_t;

   logic           clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic           cfg_mode = 1'b0, cfg_asce = 1'b0;
   logic [2:0]     cfg_fun_id = 3'd0;
   logic [NWB-1:0] cfg_len = '0;
   logic           busy, done, m_asce, m_clear_reg, m_load;
   logic [W-1:0]   m_in, m_index, m_out_nonli;
   logic [2:0]     m_fun_id;
   slots_t         ms_v = '0, ms_i = '0;
   int             ms_n = 0;

   misc_ctrl_if #(.WIDTH(W)) bus ();

   int total = 0, bad = 0, cyc = 0;
   beat_t exp_q[$];
   beat_t cmp_e;
   logic [W-1:0] vals[32];
   logic [W-1:0] got_d[32], got_i[32];
   int beat_cnt = 0, clr_cnt = 0, ld_cnt = 0, ov_cnt = 0;
   int last_cyc = -1, start_cyc = 0, first_ld_cyc = -1, done_cyc = 0;
   bit cur_ks = 0, tog = 0;
   logic pv = 1'b0;
   logic [W-1:0] pd = '0;

   misc_ctrl #(.WIDTH(W), .K(KK), .NW(NWB)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .start             (start),
      .cfg_mode          (cfg_mode),
      .cfg_fun_id        (cfg_fun_id),
      .cfg_asce          (cfg_asce),
      .cfg_len           (cfg_len),
      .busy              (busy),
      .done              (done),
      .io                (bus),
      .m_in              (m_in),
      .m_index           (m_index),
      .m_fun_id          (m_fun_id),
      .m_asce            (m_asce),
      .m_clear_reg       (m_clear_reg),
      .m_load            (m_load),
      .m_out_nonli       (m_out_nonli),
      .m_out_ksort       (ms_v),
      .m_out_ksort_index (ms_i)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in for the Misc nonlinear path.
   function automatic logic [W-1:0] nl_f(input logic [W-1:0] x, input logic [2:0] f);
      return x * (32'(f) + 32'd1) + 32'h100;
   endfunction
   assign m_out_nonli = nl_f(m_in, m_fun_id);

   function automatic int ins_pos(input logic [W-1:0] x, input logic asc, input slots_t v, input int n);
      for (int i = 0; i < n; i++) if (asc ? (x < v[i]) : (x > v[i])) return i;
      return n;
   endfunction

   function automatic slots_t ins(input slots_t a, input int p, input logic [W-1:0] x);
      slots_t r;
      for (int i = 0; i < KK; i++) begin
         if (i < p)       r[i] = a[i];
         else if (i == p) r[i] = x;
         else             r[i] = a[i-1];
      end
      return r;
   endfunction

   // Stand-in for the Misc k-sort registers: insertion into K ranked slots.
   always @(posedge clk) begin
      if (m_clear_reg) begin
         ms_v <= '0;
         ms_i <= '0;
         ms_n <= 0;
      end else if (m_load) begin
         ms_v <= ins(ms_v, ins_pos(m_in, m_asce, ms_v, ms_n), m_in);
         ms_i <= ins(ms_i, ins_pos(m_in, m_asce, ms_v, ms_n), m_index);
         ms_n <= (ms_n < KK) ? ms_n + 1 : KK;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle checker: result beats against the expected queue, stall stability, Misc feed.
   always @(negedge clk) begin
      if (!rst_n) begin
         pv <= 1'b0;
      end else begin
         if (pv) begin
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_data", bus.out_data, pd);
         end
         if (bus.out_valid) ov_cnt++;
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_beat: got data %0h with nothing expected", bus.out_data);
            end else begin
               cmp_e = exp_q.pop_front();
               chk("out_data", bus.out_data, cmp_e.d);
               chk("out_index", bus.out_index, cmp_e.i);
               chk("out_last", 32'(bus.out_last), 32'(cmp_e.l));
            end
            got_d[beat_cnt % 32] = bus.out_data;
            got_i[beat_cnt % 32] = bus.out_index;
            beat_cnt++;
            if (bus.out_last) last_cyc = cyc;
         end
         if (cur_ks && bus.out_valid) chk("in_ready_emit", 32'(bus.in_ready), 32'd0);
         if (m_clear_reg) begin
            clr_cnt++;
            ld_cnt = 0;
         end
         if (m_load) begin
            if (clr_cnt == 0) begin
               total++;
               bad++;
               $display("FAIL load_before_clear: m_load with %0d clears seen", clr_cnt);
            end
            chk("m_index", m_index, ld_cnt);
            chk("m_in", m_in, vals[ld_cnt % 32]);
            if (ld_cnt == 0) first_ld_cyc = cyc;
            ld_cnt++;
         end
         pv <= bus.out_valid && !bus.out_ready;
         pd <= bus.out_data;
      end
   end

   // Output-ready pattern: constant 1, or alternating when tog is set.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         bus.out_ready = tog ? ~bus.out_ready : 1'b1;
      end
   end

   function automatic bit better(input logic [W-1:0] va, ia, vb, ib, input bit asc);
      if (va == vb) return ia < ib;
      return asc ? (va < vb) : (va > vb);
   endfunction

   // Expected results from the whole input list: full sort, keep the best K.
   task automatic build_exp(input bit mode, input logic [2:0] fid, input bit asce, input int len);
      logic [W-1:0] sv[32], si[32], tv, ti;
      beat_t b;
      int n, best;
      exp_q.delete();
      if (!mode) begin
         for (int i = 0; i < len; i++) begin
            b.d = nl_f(vals[i], fid); b.i = '0; b.l = (i == len - 1);
            exp_q.push_back(b);
         end
      end else begin
         for (int i = 0; i < len; i++) begin sv[i] = vals[i]; si[i] = i; end
         for (int i = 0; i < len; i++) begin
            best = i;
            for (int j = i + 1; j < len; j++) if (better(sv[j], si[j], sv[best], si[best], asce)) best = j;
            tv = sv[i]; ti = si[i]; sv[i] = sv[best]; si[i] = si[best]; sv[best] = tv; si[best] = ti;
         end
         n = (len < KK) ? len : KK;
         for (int i = 0; i < n; i++) begin
            b.d = sv[i]; b.i = si[i]; b.l = (i == n - 1);
            exp_q.push_back(b);
         end
      end
   endtask

   task automatic start_job(input bit mode, input logic [2:0] fid, input bit asce, input int len, input bit hold);
      @(posedge clk); #1;
      cfg_mode = mode; cfg_fun_id = fid; cfg_asce = asce; cfg_len = NWB'(len);
      start = 1'b1; start_cyc = cyc;
      beat_cnt = 0; clr_cnt = 0; ld_cnt = 0; ov_cnt = 0; cur_ks = mode;
      first_ld_cyc = -1; last_cyc = -1;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
   endtask

   task automatic send(input int n);
      int t;
      for (int i = 0; i < n; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = vals[i];
         t = 0;
         do begin @(negedge clk); t++; end while (!bus.in_ready && t < 300);
         if (!bus.in_ready) begin
            total++; bad++;
            $display("FAIL in_ready_timeout: element %0d never accepted", i);
         end
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int t = 0;
      do begin @(negedge clk); t++; end while (!done && t < budget);
      done_cyc = cyc;
      if (!done) begin
         total++; bad++;
         $display("FAIL done_timeout: no done after %0d cycles", t);
      end
   endtask

   task automatic run_job(input bit mode, input logic [2:0] fid, input bit asce, input int len, input bit tg);
      int n_exp;
      build_exp(mode, fid, asce, len);
      n_exp = exp_q.size();
      tog = tg;
      start_job(mode, fid, asce, len, 1'b0);
      send(len);
      wait_done(600);
      chk("beats", beat_cnt, n_exp);
      chk("exp_left", exp_q.size(), 0);
      chk("busy_at_done", 32'(busy), 32'd0);
      chk("clear_pulses", clr_cnt, mode ? 1 : 0);
      if (len > 0) chk("done_after_last", done_cyc, last_cyc + 1);
      else         chk("no_valid", ov_cnt, 0);
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'd0);
      tog = 1'b0;
   endtask

   task automatic reset_checks();
      chk("rst_busy", 32'(busy), 0);           chk("rst_done", 32'(done), 0);
      chk("rst_in_ready", 32'(bus.in_ready), 0); chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out_last", 32'(bus.out_last), 0); chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_index", bus.out_index, 0);  chk("rst_m_in", m_in, 0);
      chk("rst_m_index", m_index, 0);          chk("rst_m_fun_id", 32'(m_fun_id), 0);
      chk("rst_m_asce", 32'(m_asce), 0);       chk("rst_m_clear", 32'(m_clear_reg), 0);
      chk("rst_m_load", 32'(m_load), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] e1d[5], e1i[5];
      e1d = '{32'd1, 32'd3, 32'd5, 32'd7, 32'd9};
      e1i = '{32'd3, 32'd1, 32'd4, 32'd2, 32'd0};
      bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_checks();
      rst_n = 1'b1;

      // k-sort, five elements, ascending
      vals[0] = 9; vals[1] = 3; vals[2] = 7; vals[3] = 1; vals[4] = 5;
      run_job(MODE_KSORT, FUN_SIGMOID, 1'b1, 5, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk("t1_lit_data", got_d[i], e1d[i]);
         chk("t1_lit_index", got_i[i], e1i[i]);
      end
      chk("t1_load_latency", first_ld_cyc - start_cyc, 3);

      // k-sort, more elements than slots, descending
      for (int i = 0; i < 25; i++) vals[i] = $urandom;
      run_job(MODE_KSORT, FUN_SIGMOID, 1'b0, 25, 1'b0);
      chk("t2_loads", ld_cnt, 25);

      // empty jobs in both modes
      run_job(MODE_KSORT, FUN_SIGMOID, 1'b1, 0, 1'b0);
      run_job(MODE_NL, FUN_EXP, 1'b0, 0, 1'b0);

      // nonlinear with a stalling consumer
      vals[0] = 4; vals[1] = 10; vals[2] = 0; vals[3] = 1;
      vals[4] = 100; vals[5] = 7; vals[6] = 32'hFFFF; vals[7] = 32'hFFFF_FFF0;
      run_job(MODE_NL, FUN_EXP, 1'b0, 8, 1'b1);
      chk("t4_lit0", got_d[0], 32'h10C);
      chk("t4_lit1", got_d[1], 32'h11E);
      chk("t4_lit_index", got_i[7], 32'd0);

      // start held during a job, then reset mid-feed
      for (int i = 0; i < 6; i++) vals[i] = 11 * (i + 1);
      exp_q.delete();
      start_job(MODE_KSORT, FUN_LOG, 1'b1, 6, 1'b1);
      cfg_asce = 1'b0; cfg_fun_id = 3'd5; cfg_mode = MODE_NL;
      send(3);
      @(negedge clk);
      chk("t5_asce_kept", 32'(m_asce), 32'd1);
      chk("t5_fun_kept", 32'(m_fun_id), 32'(FUN_LOG));
      chk("t5_busy", 32'(busy), 32'd1);
      chk("t5_one_clear", clr_cnt, 1);
      start = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      reset_checks();
      exp_q.delete();
      rst_n = 1'b1;
      vals[0] = 8; vals[1] = 2; vals[2] = 6; vals[3] = 4;
      run_job(MODE_KSORT, FUN_TANH, 1'b0, 4, 1'b1);
      chk("t5_lit_first", got_d[0], 32'd8);
      chk("t5_lit_last_idx", got_i[3], 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/misc_ctrl.md
# misc_ctrl

Job sequencer for the PuDianNao Misc unit (nonlinear function + k-sort). It accepts one job at a time from the top-level controller and streams operands from a valid/ready source into Misc. In k-sort mode it clears the sort registers, tags each operand with a running index, then drains the K best (value, index) pairs as a stream. In nonlinear mode it wraps the combinational nonlinear path in a 1-deep registered stream stage.

## Interface
Parameters:
- WIDTH, 32, operand/result width
- K, 20, k-sort depth
- NW, 16, width of job length / index counter

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  job request; accepted only when busy=0
- cfg_mode  in  1  0 = nonlinear, 1 = k-sort
- cfg_fun_id  in  3  nonlinear function id
- cfg_asce  in  1  1 = ascending sort
- cfg_len  in  NW  number of input elements
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end
- in_valid / in_ready  in / out  1  operand stream handshake
- in_data  in  WIDTH  operand
- out_valid / out_ready  out / in  1  result stream handshake
- out_data  out  WIDTH  result value
- out_index  out  WIDTH  sort index (zero in nonlinear mode)
- out_last  out  1  marks final result beat
- m_in, m_index  out  WIDTH  Misc operand and index (registered)
- m_fun_id  out  3 / m_asce  out  1  latched job config
- m_clear_reg  out  1  sort-register clear
- m_load  out  1  one-cycle strobe: m_in/m_index hold a new element
- m_out_nonli  in  WIDTH  nonlinear result
- m_out_ksort, m_out_ksort_index  in  WIDTH x K  sorted slots, rank 0 first

## Operation
- States: IDLE, CLEAR, FEED, SETTLE, EMIT, NL.
- IDLE: busy=0, in_ready=0. start=1 latches cfg_* and moves to CLEAR if cfg_mode=1, otherwise to NL.
- CLEAR (1 cycle): m_clear_reg=1, element counter cnt=0, then FEED.
- FEED: in_ready=1. On each handshake: m_in<=in_data, m_index<=zero-extended cnt, m_load=1 next cycle, cnt++. After beat cfg_len is accepted, go to SETTLE. If cfg_len=0, CLEAR goes straight to SETTLE.
- SETTLE (1 cycle): no activity; lets the sort registers absorb the last element. Then EMIT with n_out = min(cfg_len, K).
- EMIT: presents slot s = 0..n_out-1 as out_data=m_out_ksort[s] and out_index=m_out_ksort_index[s], registered. s advances on out_valid&&out_ready. out_last=1 on slot n_out-1. After the last handshake: done=1, go to IDLE. If n_out=0: no beats, done in the cycle after SETTLE.
- NL: in_ready = !out_valid || out_ready. On each input handshake the out register loads m_out_nonli for m_in=in_data; m_in is driven combinationally from in_data in this mode. out_index=0. out_last=1 on element cfg_len. After the last output handshake: done, then IDLE. If cfg_len=0: done the next cycle.
- start while busy=1 is ignored. Config is stable from acceptance to done.
- cnt saturates at cfg_len. Extra input is refused with in_ready=0.

## Timing
- Reset (rst_n=0 at a clk edge): state IDLE. Every output is 0: busy, done, in_ready, out_valid, out_last, out_data, out_index, m_*, m_clear_reg, m_load. Reset mid-job abandons the job without asserting done.
- busy rises the cycle after start is accepted and falls in the same cycle done pulses.
- K-sort latency: start to first m_load = 3 cycles at full input rate; last input to first out_valid = 2 cycles (m_load, SETTLE); then one result per cycle with out_ready=1.
- NL latency: 1 cycle input to output. Full throughput with out_ready=1. A stalled output holds out_data stable and drops in_ready.
- out_valid, once high, stays high with stable data until accepted.

## Structure
- Package misc_pkg: state enum (IDLE, CLEAR, FEED, SETTLE, EMIT, NL), mode constants MODE_NL=0 and MODE_KSORT=1, fun_id constants shared with nonlinear.
- A single sub-module is natural: misc_out_reg, the 1-deep valid/ready output register used by both EMIT and NL.

## Test plan
- K-sort, len=5, asce=1, inputs 9,3,7,1,5, out_ready=1: exactly 5 beats in rank order with out_index as produced by Misc; out_last on beat 5; done one cycle after.
- K-sort, len=25 (>K), random inputs: exactly 20 beats; m_clear_reg pulses once, before the first m_load; m_index runs 0..24.
- len=0 in both modes: no out_valid; done pulses; busy drops; m_clear_reg still pulses in k-sort mode.
- NL, fun_id=2, len=8, out_ready toggling 1/0: 8 results in order, no drops or duplicates, out_data stable while stalled.
- start held high during a job, then rst_n=0 mid-FEED: the second start is ignored; after reset all outputs are 0, and a new job runs correctly.
